// File: rtl/npu_mem_pkg.sv
// Shared definitions for the NPU weight memory: burst FSM states and wrapped address arithmetic.
package npu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } burst_state_e;

    // (a + b) mod depth, valid for a < depth and b <= depth.
    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned depth);
        int unsigned s;
        s = a + b;
        if (s >= depth) begin
            s = s - depth;
        end
        return s;
    endfunction

endpackage

// File: rtl/weight_bram_bank.sv
// One word-interleaved weight bank: single write port, single registered read port.
module weight_bram_bank #(
    parameter int unsigned ROWS  = 196,
    parameter int unsigned ROW_W = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [ROW_W-1:0] rd_row,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [ROWS];

    // Non-blocking read and write give old-data semantics on a same-row collision.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_row];
        end
    end

endmodule

// File: rtl/weight_bram_stream.sv
// Weight store with burst-read engine: NUM_LANES interleaved banks, lane rotation for unaligned
// bases, credit-gated issue into a 2-entry output skid buffer.
module weight_bram_stream
    import npu_mem_pkg::*;
#(
    parameter int unsigned BRAM_ADDR_WIDTH = 10,
    parameter int unsigned WEIGHT_WIDTH    = 8,
    parameter int unsigned BRAM_DEPTH      = 784,
    parameter int unsigned NUM_LANES       = 4,
    parameter int unsigned LEN_WIDTH       = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              wr_en,
    input  logic [BRAM_ADDR_WIDTH-1:0]        wr_addr,
    input  logic [WEIGHT_WIDTH-1:0]           wr_data,
    input  logic                              i_start,
    input  logic [BRAM_ADDR_WIDTH-1:0]        i_base_addr,
    input  logic [LEN_WIDTH-1:0]              i_num_beats,
    output logic                              o_busy,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [NUM_LANES*WEIGHT_WIDTH-1:0] o_data,
    output logic                              o_last,
    output logic                              o_done,
    output logic                              o_err
);

    localparam int unsigned ROWS   = BRAM_DEPTH / NUM_LANES;
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned DATA_W = NUM_LANES * WEIGHT_WIDTH;

    burst_state_e               state_q, state_d;
    logic [BRAM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0]       beats_q, beats_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    logic                       rd_vld_q, rd_last_q;
    logic [LANE_W-1:0]          rd_rot_q;

    logic [1:0]                 cnt_q, cnt_d;
    logic [DATA_W-1:0]          slot0_data_q, slot0_data_d, slot1_data_q, slot1_data_d;
    logic                       slot0_last_q, slot0_last_d, slot1_last_q, slot1_last_d;

    logic [WEIGHT_WIDTH-1:0]    bank_rd [NUM_LANES];
    logic [DATA_W-1:0]          rot_data;
    logic [2:0]                 occ;
    logic                       credit_ok, issue, push, pop;
    int unsigned                rot_now;

    assign rot_now = 32'(ptr_q) % NUM_LANES;

    // Banks: bank b holds words with addr mod NUM_LANES == b, at row addr / NUM_LANES.
    for (genvar b = 0; b < NUM_LANES; b++) begin : g_bank
        localparam int unsigned BANK = b;
        logic [ROW_W-1:0] rd_row;
        logic             bank_we;

        // Lane feeding this bank is (BANK - rot) mod NUM_LANES within the current beat.
        always_comb begin
            rd_row = ROW_W'(wrap_add(32'(ptr_q), (BANK + NUM_LANES - rot_now) % NUM_LANES,
                                     BRAM_DEPTH) / NUM_LANES);
        end

        assign bank_we = wr_en && (32'(wr_addr) < BRAM_DEPTH)
                         && ((32'(wr_addr) % NUM_LANES) == BANK);

        weight_bram_bank #(
            .ROWS  (ROWS),
            .ROW_W (ROW_W),
            .WIDTH (WEIGHT_WIDTH)
        ) u_bank (
            .i_clk   (i_clk),
            .wr_en   (bank_we),
            .wr_row  (ROW_W'(32'(wr_addr) / NUM_LANES)),
            .wr_data (wr_data),
            .rd_en   (issue),
            .rd_row  (rd_row),
            .rd_data (bank_rd[b])
        );
    end

    always_comb begin
        rot_data = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            rot_data[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
                bank_rd[LANE_W'((32'(rd_rot_q) + k) % NUM_LANES)];
        end
    end

    // Buffered plus in-flight beats may never exceed the two skid slots.
    assign pop       = (cnt_q != 2'd0) && i_ready;
    assign push      = rd_vld_q;
    assign occ       = {1'b0, cnt_q} + {2'b00, rd_vld_q};
    assign credit_ok = (occ - {2'b00, pop}) <= 3'd1;
    assign issue     = (state_q == FETCH) && credit_ok;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        beats_d = beats_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (32'(i_base_addr) >= BRAM_DEPTH) begin
                        err_d = 1'b1;
                    end else if (i_num_beats == '0) begin
                        done_d = 1'b1;
                    end else begin
                        ptr_d   = i_base_addr;
                        beats_d = i_num_beats;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (issue) begin
                    ptr_d   = BRAM_ADDR_WIDTH'(wrap_add(32'(ptr_q), NUM_LANES, BRAM_DEPTH));
                    beats_d = beats_q - LEN_WIDTH'(1);
                    if (beats_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && slot0_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        slot0_data_d = slot0_data_q;
        slot0_last_d = slot0_last_q;
        slot1_data_d = slot1_data_q;
        slot1_last_d = slot1_last_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    slot0_data_d = rot_data;
                    slot0_last_d = rd_last_q;
                end else begin
                    slot1_data_d = rot_data;
                    slot1_last_d = rd_last_q;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                if (cnt_q == 2'd2) begin
                    slot0_data_d = slot1_data_q;
                    slot0_last_d = slot1_last_q;
                end
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    slot0_data_d = rot_data;
                    slot0_last_d = rd_last_q;
                end else begin
                    slot0_data_d = slot1_data_q;
                    slot0_last_d = slot1_last_q;
                    slot1_data_d = rot_data;
                    slot1_last_d = rd_last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            beats_q      <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_rot_q     <= '0;
            cnt_q        <= 2'd0;
            slot0_data_q <= '0;
            slot0_last_q <= 1'b0;
            slot1_data_q <= '0;
            slot1_last_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            beats_q      <= beats_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rd_vld_q     <= issue;
            rd_last_q    <= (beats_q == LEN_WIDTH'(1));
            rd_rot_q     <= LANE_W'(rot_now);
            cnt_q        <= cnt_d;
            slot0_data_q <= slot0_data_d;
            slot0_last_q <= slot0_last_d;
            slot1_data_q <= slot1_data_d;
            slot1_last_q <= slot1_last_d;
        end
    end

    assign o_busy  = (state_q != IDLE);
    assign o_valid = (cnt_q != 2'd0);
    assign o_data  = slot0_data_q;
    assign o_last  = slot0_last_q && (cnt_q != 2'd0);
    assign o_done  = done_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_weight_bram_stream.sv
// Scoreboard bench for weight_bram_stream: stimulus pushes expected beats, a monitor pops on handshake.
module tb_weight_bram_stream;

    localparam int unsigned DEPTH = 784;
    localparam int unsigned LANES = 4;

    logic        i_clk;
    logic        i_rst_n;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        i_start;
    logic [9:0]  i_base_addr;
    logic [7:0]  i_num_beats;
    logic        o_busy;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_last;
    logic        o_done;
    logic        o_err;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    total  = 0;
    int    bad    = 0;
    int    hs_cnt = 0;

    weight_bram_stream dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_num_beats (i_num_beats),
        .o_busy      (o_busy),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_last      (o_last),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    // Memory holds addr[7:0] at every word, so a beat is predictable from its addresses.
    task automatic expect_burst(input int unsigned base, input int unsigned beats);
        logic [31:0] d;
        int unsigned w;
        for (int unsigned j = 0; j < beats; j++) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                w = (base + j * LANES + k) % DEPTH;
                d[k*8 +: 8] = w[7:0];
            end
            expect_beat(d, j == beats - 1);
        end
    endtask

    // Returns 1 ns after the accepting edge, so the next negedge samples that edge's result.
    task automatic start(input logic [9:0] base, input logic [7:0] beats);
        @(posedge i_clk); #1;
        i_start     = 1'b1;
        i_base_addr = base;
        i_num_beats = beats;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge i_clk);
            if (o_done) seen = 1'b1;
        end
        chk(name, 64'(seen), 64'd1);
    endtask

    task automatic write_word(input logic [9:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge i_clk); #1;
        wr_en = 1'b0;
    endtask

    // Monitor: compares every handshaken beat and every stalled beat against the queue head.
    initial begin
        beat_t e;
        forever begin
            @(negedge i_clk);
            if (i_rst_n) begin
                if (o_valid && !i_ready && exp_q.size() > 0) begin
                    chk("stall_data", 64'(o_data), 64'(exp_q[0].data));
                    chk("stall_last", 64'(o_last), 64'(exp_q[0].last));
                end
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got %h, required no beat", o_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 64'(o_data), 64'(e.data));
                        chk("beat_last", 64'(o_last), 64'(e.last));
                    end
                    hs_cnt++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat [8];
        int         hs0;
        pat = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1};

        i_rst_n     = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_num_beats = '0;
        i_ready     = 1'b1;
        #2;
        chk("rst_busy",  64'(o_busy),  64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_data",  64'(o_data),  64'd0);
        chk("rst_last",  64'(o_last),  64'd0);
        chk("rst_done",  64'(o_done),  64'd0);
        chk("rst_err",   64'(o_err),   64'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        for (int a = 0; a < int'(DEPTH); a++) begin
            write_word(10'(a), 8'(a));
        end

        // Aligned burst with cycle-accurate valid/last/done/busy checks.
        expect_beat(32'h03020100, 1'b0);
        expect_beat(32'h07060504, 1'b0);
        expect_beat(32'h0B0A0908, 1'b0);
        expect_beat(32'h0F0E0D0C, 1'b1);
        start(10'd0, 8'd4);
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            chk("t1_valid", 64'(o_valid), 64'(c >= 2 && c <= 5));
            chk("t1_last",  64'(o_last),  64'(c == 5));
            chk("t1_done",  64'(o_done),  64'(c == 6));
            chk("t1_busy",  64'(o_busy),  64'(c <= 5));
        end

        // Unaligned base wrapping past the end of memory.
        expect_beat(32'h01000F0E, 1'b0);
        expect_beat(32'h05040302, 1'b1);
        start(10'd782, 8'd2);
        wait_done("wrap_done");

        // Backpressure with an irregular ready pattern.
        expect_burst(0, 8);
        start(10'd0, 8'd8);
        @(posedge i_clk); #1;
        for (int i = 0; i < 8; i++) begin
            i_ready = pat[i][0];
            @(posedge i_clk); #1;
        end
        i_ready = 1'b1;
        wait_done("bp_done");

        // Out-of-range base: error pulse, no burst.
        start(10'd800, 8'd2);
        @(negedge i_clk);
        chk("err_pulse", 64'(o_err),  64'd1);
        chk("err_busy",  64'(o_busy), 64'd0);
        chk("err_done",  64'(o_done), 64'd0);
        @(negedge i_clk);
        chk("err_clear", 64'(o_err),  64'd0);

        // Zero-length burst: done pulse only.
        start(10'd10, 8'd0);
        @(negedge i_clk);
        chk("zero_done", 64'(o_done), 64'd1);
        chk("zero_busy", 64'(o_busy), 64'd0);
        chk("zero_err",  64'(o_err),  64'd0);
        @(negedge i_clk);
        chk("zero_clear", 64'(o_done), 64'd0);

        // Starts while busy are ignored.
        expect_burst(0, 4);
        start(10'd0, 8'd4);
        start(10'd800, 8'd1);
        @(negedge i_clk);
        chk("busy_no_err",  64'(o_err),  64'd0);
        chk("busy_no_done", 64'(o_done), 64'd0);
        start(10'd100, 8'd2);
        wait_done("busy_done");
        repeat (4) @(negedge i_clk);
        chk("busy_idle", 64'(o_busy), 64'd0);

        // Read-during-write on word 4: beat keeps old data, next burst sees the new value.
        expect_beat(32'h07060504, 1'b1);
        start(10'd4, 8'd1);
        write_word(10'd4, 8'hAA);
        wait_done("raw_done1");
        expect_beat(32'h070605AA, 1'b1);
        start(10'd4, 8'd1);
        wait_done("raw_done2");
        @(posedge i_clk); #1;
        write_word(10'd4, 8'h04);

        // Reset in the middle of an 8-beat burst.
        expect_burst(0, 8);
        hs0 = hs_cnt;
        start(10'd0, 8'd8);
        for (int i = 0; i < 40 && hs_cnt < hs0 + 3; i++) begin
            @(posedge i_clk); #1;
        end
        chk("rst_reach_beat3", 64'(hs_cnt - hs0), 64'd3);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  64'(o_busy),  64'd0);
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_data",  64'(o_data),  64'd0);
        chk("mid_rst_last",  64'(o_last),  64'd0);
        chk("mid_rst_done",  64'(o_done),  64'd0);
        exp_q.delete();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        expect_beat(32'h03020100, 1'b0);
        expect_beat(32'h07060504, 1'b1);
        start(10'd0, 8'd2);
        wait_done("post_rst_done");

        repeat (3) @(negedge i_clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
